// File: rtl/pass_through_fifo_if.sv
// pass_through_fifo_if: one AXI-Stream link between the packet adapter and the CMAC.
//
// Signals:
//   tvalid    - beat valid (master -> slave)
//   tready    - beat accepted (slave -> master)
//   tdata     - DATA_W payload
//   tkeep     - KEEP_W byte enables
//   tlast     - last beat of a frame
//   tuser_err - frame error flag, meaningful on the tlast beat
//
// Modports:
//   master - drives the beat, samples tready
//   slave  - samples the beat, drives tready
interface pass_through_fifo_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = DATA_W / 8
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser_err;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    output tuser_err,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tuser_err,
    output tready
  );

endinterface

// File: rtl/pass_through_fifo.sv
// pass_through_fifo: two independent DEPTH-entry elastic FIFOs between the packet
// adapter and the CMAC core, one per AXI-Stream direction, so that tready never
// passes combinationally from one side to the other.
//
// Ports:
//   cmac_clk    - sole clock
//   rst         - synchronous active-high reset (pointers, counters)
//   s_axis_adap - TX ingress from adapter (slave)
//   m_axis_cmac - TX egress to CMAC (master)
//   s_axis_cmac - RX ingress from CMAC (slave)
//   m_axis_adap - RX egress to adapter (master)
//   stats_clr   - synchronous clear of all statistics counters
//   tx_pkt_cnt, tx_err_cnt, rx_pkt_cnt, rx_err_cnt - saturating frame / error counters
//
// Optional feature: define PASS_THROUGH_FIFO_STATS_EN to build the counters. Without it
// the counters read 0, stats_clr is ignored and the datapath is unchanged.
module pass_through_fifo #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                cmac_clk,
  input  logic                rst,
  pass_through_fifo_if.slave  s_axis_adap,
  pass_through_fifo_if.master m_axis_cmac,
  pass_through_fifo_if.slave  s_axis_cmac,
  pass_through_fifo_if.master m_axis_adap,
  input  logic                stats_clr,
  output logic [CNT_W-1:0]    tx_pkt_cnt,
  output logic [CNT_W-1:0]    tx_err_cnt,
  output logic [CNT_W-1:0]    rx_pkt_cnt,
  output logic [CNT_W-1:0]    rx_err_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;
  // Entry layout: {tdata, tkeep, tlast, tuser_err}
  localparam int unsigned EntW = DATA_W + KEEP_W + 2;

  // Channel 0 is TX (adapter -> CMAC), channel 1 is RX (CMAC -> adapter).
  logic [1:0]           in_valid;
  logic [1:0]           in_ready;
  logic [1:0][EntW-1:0] in_entry;
  logic [1:0]           out_valid;
  logic [1:0]           out_ready;
  logic [1:0][EntW-1:0] out_entry;
  logic [1:0]           fin;      // egress handshake on a tlast beat
  logic [1:0]           err_fin;  // same, with tuser_err set

  assign in_valid[0]   = s_axis_adap.tvalid;
  assign in_entry[0]   = {s_axis_adap.tdata, s_axis_adap.tkeep, s_axis_adap.tlast,
                          s_axis_adap.tuser_err};
  assign s_axis_adap.tready = in_ready[0];
  assign m_axis_cmac.tvalid = out_valid[0];
  assign {m_axis_cmac.tdata, m_axis_cmac.tkeep, m_axis_cmac.tlast,
          m_axis_cmac.tuser_err} = out_entry[0];
  assign out_ready[0]  = m_axis_cmac.tready;

  assign in_valid[1]   = s_axis_cmac.tvalid;
  assign in_entry[1]   = {s_axis_cmac.tdata, s_axis_cmac.tkeep, s_axis_cmac.tlast,
                          s_axis_cmac.tuser_err};
  assign s_axis_cmac.tready = in_ready[1];
  assign m_axis_adap.tvalid = out_valid[1];
  assign {m_axis_adap.tdata, m_axis_adap.tkeep, m_axis_adap.tlast,
          m_axis_adap.tuser_err} = out_entry[1];
  assign out_ready[1]  = m_axis_adap.tready;

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [EntW-1:0] mem_q [DEPTH];
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Ready looks only at local state, never at the egress tready.
    assign in_ready[c]  = !full && !rst;
    assign push         = in_valid[c] && in_ready[c];
    assign out_valid[c] = !empty;
    assign pop          = out_valid[c] && out_ready[c];

    assign out_entry[c] = out_valid[c] ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign fin[c]       = pop && out_entry[c][1];
    assign err_fin[c]   = pop && out_entry[c][1] && out_entry[c][0];

    always_ff @(posedge cmac_clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge cmac_clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_entry[c];
    end
  end

`ifdef PASS_THROUGH_FIFO_STATS_EN
  // Index: 0 tx_pkt, 1 tx_err, 2 rx_pkt, 3 rx_err
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0]            inc;

  assign inc = {err_fin[1], fin[1], err_fin[0], fin[0]};

  always_ff @(posedge cmac_clk) begin
    if (rst || stats_clr) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign tx_pkt_cnt = cnt_q[0];
  assign tx_err_cnt = cnt_q[1];
  assign rx_pkt_cnt = cnt_q[2];
  assign rx_err_cnt = cnt_q[3];
`else
  logic unused_stats;
  assign unused_stats = ^{stats_clr, fin, err_fin};

  assign tx_pkt_cnt = '0;
  assign tx_err_cnt = '0;
  assign rx_pkt_cnt = '0;
  assign rx_err_cnt = '0;
`endif

endmodule

// File: tb/tb_pass_through_fifo.sv
// tb_pass_through_fifo: directed self-checking bench for pass_through_fifo
// (DATA_W=32, DEPTH=4, CNT_W=4). Expected counter values follow the build macro.
module tb_pass_through_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;
`ifdef PASS_THROUGH_FIFO_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stats_clr = 1'b0;
  logic [CW-1:0] tx_pkt, tx_err, rx_pkt, rx_err;

  always #5 clk = ~clk;

  pass_through_fifo_if #(.DATA_W(DW)) tx_in ();
  pass_through_fifo_if #(.DATA_W(DW)) tx_out ();
  pass_through_fifo_if #(.DATA_W(DW)) rx_in ();
  pass_through_fifo_if #(.DATA_W(DW)) rx_out ();

  pass_through_fifo #(
    .DATA_W(DW),
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) dut (
    .cmac_clk   (clk),
    .rst        (rst),
    .s_axis_adap(tx_in),
    .m_axis_cmac(tx_out),
    .s_axis_cmac(rx_in),
    .m_axis_adap(rx_out),
    .stats_clr  (stats_clr),
    .tx_pkt_cnt (tx_pkt),
    .tx_err_cnt (tx_err),
    .rx_pkt_cnt (rx_pkt),
    .rx_err_cnt (rx_err)
  );

  int checks = 0;
  int failures = 0;

  bit [31:0] rx_d [3] = '{32'hA0, 32'hA1, 32'hB0};
  bit        rx_l [3] = '{1'b0, 1'b1, 1'b1};
  bit        rx_e [3] = '{1'b0, 1'b1, 1'b0};

  function automatic logic [3:0] keep_of(input logic [31:0] d);
    return d[3:0] ^ 4'hA;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_tx(input logic v, input logic [31:0] d, input logic l, input logic e);
    tx_in.tvalid    = v;
    tx_in.tdata     = d;
    tx_in.tkeep     = keep_of(d);
    tx_in.tlast     = l;
    tx_in.tuser_err = e;
  endtask

  task automatic drv_rx(input logic v, input logic [31:0] d, input logic l, input logic e);
    rx_in.tvalid    = v;
    rx_in.tdata     = d;
    rx_in.tkeep     = keep_of(d);
    rx_in.tlast     = l;
    rx_in.tuser_err = e;
  endtask

  initial begin
    drv_tx(1'b0, 32'h0, 1'b0, 1'b0);
    drv_rx(1'b0, 32'h0, 1'b0, 1'b0);
    tx_out.tready = 1'b0;
    rx_out.tready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_tx_tready", tx_in.tready, 1'b0);
    chk("rst_rx_tready", rx_in.tready, 1'b0);
    chk("rst_tx_tvalid", tx_out.tvalid, 1'b0);
    chk("rst_tx_tdata", tx_out.tdata, 32'h0);
    chk("rst_rx_tvalid", rx_out.tvalid, 1'b0);
    chk("rst_tx_pkt", tx_pkt, 4'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_tx_tready", tx_in.tready, 1'b1);

    // 3-beat frame, egress ready held high: beat i seen one cycle after acceptance
    tx_out.tready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drv_tx(1'b1, 32'(i), (i == 3), 1'b0);
      tick();
      chk("f1_tvalid", tx_out.tvalid, 1'b1);
      chk("f1_tdata", tx_out.tdata, 64'(i));
      chk("f1_tlast", tx_out.tlast, (i == 3));
      chk("f1_tkeep", tx_out.tkeep, keep_of(32'(i)));
    end
    drv_tx(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("f1_drained_tvalid", tx_out.tvalid, 1'b0);
    chk("f1_drained_tdata", tx_out.tdata, 32'h0);
    chk("f1_tx_pkt", tx_pkt, StatsEn ? 4'd1 : 4'd0);

    // Fill with egress stalled; head beat holds steady
    tx_out.tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_tready", tx_in.tready, 1'b1);
      drv_tx(1'b1, 32'h10 + 32'(i), (i == 3), 1'b0);
      tick();
      chk("fill_head_stable", tx_out.tdata, 32'h10);
    end
    chk("full_tready", tx_in.tready, 1'b0);

    // Full with push and pop offered together: only the pop happens
    drv_tx(1'b1, 32'h14, 1'b1, 1'b0);
    tx_out.tready = 1'b1;
    #1;
    chk("full_tready_indep", tx_in.tready, 1'b0);
    tick();
    chk("occ3_tready", tx_in.tready, 1'b1);
    chk("drain_0x11", tx_out.tdata, 32'h11);
    tick();
    drv_tx(1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_0x12", tx_out.tdata, 32'h12);
    tick();
    chk("drain_0x13", tx_out.tdata, 32'h13);
    chk("drain_0x13_last", tx_out.tlast, 1'b1);
    tick();
    chk("drain_0x14", tx_out.tdata, 32'h14);
    tick();
    chk("drain_empty", tx_out.tvalid, 1'b0);
    chk("drain_tx_pkt", tx_pkt, StatsEn ? 4'd3 : 4'd0);

    // RX: errored frame then a clean frame
    rx_out.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_rx(1'b1, rx_d[i], rx_l[i], rx_e[i]);
      tick();
      chk("rx_tvalid", rx_out.tvalid, 1'b1);
      chk("rx_tdata", rx_out.tdata, rx_d[i]);
      chk("rx_tkeep", rx_out.tkeep, keep_of(rx_d[i]));
      chk("rx_tlast", rx_out.tlast, rx_l[i]);
      chk("rx_terr", rx_out.tuser_err, rx_e[i]);
    end
    drv_rx(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("rx_empty", rx_out.tvalid, 1'b0);
    chk("rx_pkt", rx_pkt, StatsEn ? 4'd2 : 4'd0);
    chk("rx_err", rx_err, StatsEn ? 4'd1 : 4'd0);
    chk("tx_err_clean", tx_err, 4'd0);

    // Reset mid-frame: buffered beats are discarded
    tx_out.tready = 1'b0;
    drv_tx(1'b1, 32'hC0, 1'b0, 1'b0);
    tick();
    drv_tx(1'b1, 32'hC1, 1'b0, 1'b0);
    tick();
    drv_tx(1'b0, 32'h0, 1'b0, 1'b0);
    chk("midrst_held", tx_out.tdata, 32'hC0);
    rst = 1'b1;
    #1;
    chk("midrst_tx_tready", tx_in.tready, 1'b0);
    chk("midrst_rx_tready", rx_in.tready, 1'b0);
    tick();
    chk("midrst_tvalid", tx_out.tvalid, 1'b0);
    chk("midrst_tdata", tx_out.tdata, 32'h0);
    chk("midrst_tx_pkt", tx_pkt, 4'd0);
    chk("midrst_rx_pkt", rx_pkt, 4'd0);
    chk("midrst_rx_err", rx_err, 4'd0);
    rst = 1'b0;
    tx_out.tready = 1'b1;
    #1;
    chk("midrst_release_tready", tx_in.tready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_residue", tx_out.tvalid, 1'b0);
    end

    // Saturation at 2^CW-1
    for (int i = 0; i < 15; i++) begin
      drv_tx(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    drv_tx(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("sat_15", tx_pkt, StatsEn ? 4'd15 : 4'd0);
    drv_tx(1'b1, 32'h55, 1'b1, 1'b0);
    tick();
    drv_tx(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("sat_hold", tx_pkt, StatsEn ? 4'd15 : 4'd0);

    // Clear coincident with a tlast handshake wins
    drv_tx(1'b1, 32'h66, 1'b1, 1'b0);
    tick();
    drv_tx(1'b0, 32'h0, 1'b0, 1'b0);
    chk("clr_beat_valid", tx_out.tvalid, 1'b1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("clr_tx_pkt", tx_pkt, 4'd0);
    chk("clr_tx_err", tx_err, 4'd0);
    chk("clr_beat_gone", tx_out.tvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pass_through_fifo.md
# pass_through_fifo

Parametrised successor to the direct adapter/CMAC pass-through. It sits between the packet adapter and the CMAC core on `cmac_clk` and carries both AXI-Stream directions:
- TX: adapter → CMAC.
- RX: CMAC → adapter.

Each direction gets a DEPTH-entry elastic FIFO. This decouples `tready` combinationally between the two sides. Optional per-direction packet and error statistics are available.

## Interface
Parameters:
- `DATA_W`, 512: tdata width in bits; must be a multiple of 8.
- `KEEP_W`, `DATA_W/8`: tkeep width (derived; do not override).
- `DEPTH`, 4: FIFO entries per direction; power of two, ≥2.
- `CNT_W`, 32: statistics counter width.

Ports:
- `cmac_clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_adap_tvalid/tdata/tkeep/tlast/tuser_err` in 1/DATA_W/KEEP_W/1/1: TX ingress from adapter.
- `s_axis_adap_tready` out 1: TX ingress ready.
- `m_axis_cmac_tvalid/tdata/tkeep/tlast/tuser_err` out 1/DATA_W/KEEP_W/1/1: TX egress to CMAC.
- `m_axis_cmac_tready` in 1: TX egress ready.
- `s_axis_cmac_tvalid/tdata/tkeep/tlast/tuser_err` in 1/DATA_W/KEEP_W/1/1: RX ingress from CMAC.
- `s_axis_cmac_tready` out 1: RX ingress ready.
- `m_axis_adap_tvalid/tdata/tkeep/tlast/tuser_err` out 1/DATA_W/KEEP_W/1/1: RX egress to adapter.
- `m_axis_adap_tready` in 1: RX egress ready.
- `stats_clr` in 1: synchronous clear of all counters.
- `tx_pkt_cnt`, `tx_err_cnt`, `rx_pkt_cnt`, `rx_err_cnt` out CNT_W each: statistics.

## Operation
- TX and RX are identical, independent instances of one FIFO channel. They share only the clock, reset and stats.
- FIFO entry: {tdata, tkeep, tlast, tuser_err}. Storage is a register array and is not reset.
- Pointers: write and read pointers are log2(DEPTH)+1 bits wide. The extra MSB is a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- `s_*_tready` = !full && !rst. Push occurs on s_tvalid && s_tready.
- `m_*_tvalid` = !empty. Pop occurs on m_tvalid && m_tready.
- Egress payload is read from the entry at the read pointer. It is forced to 0 while m_tvalid is low.
- Simultaneous push and pop:
  - Both are legal when neither full nor empty; occupancy is unchanged.
  - When full, push is blocked even if a pop occurs that cycle. Ready is not combinationally dependent on m_tready.
  - When empty, there is no bypass path.
- Payload and tuser_err pass unmodified. Errored frames are not dropped.
- A valid beat is never dropped or duplicated, and beat order is preserved.

## Timing
- Latency: a beat accepted at the ingress in cycle N is presented at the egress from cycle N+1.
- Throughput: 1 beat/cycle per direction sustained when egress ready is held high, for any DEPTH ≥2.
- Reset (`rst` high, sampled at the `cmac_clk` edge):
  - Pointers return to 0 and all tvalid go 0.
  - All s_tready are 0 while `rst` is high. Ready asserts in the first cycle after `rst` deasserts.
  - All egress payloads are 0 and all counters are 0.
- Reset mid-packet discards all buffered beats. No partial frame is emitted afterwards.
- Egress holds payload stable while tvalid && !tready. This follows from the pointer not advancing.

## Configuration
- Macro: `PASS_THROUGH_FIFO_STATS_EN`.
- When defined, the four counters are live:
  - pkt_cnt increments on each egress handshake with tlast=1.
  - err_cnt increments on each egress handshake with tlast=1 and tuser_err=1.
  - Counters saturate at 2^CNT_W−1.
  - `stats_clr` zeroes all four counters next cycle and takes priority over a same-cycle increment.
- When undefined, counters are tied to 0, `stats_clr` is ignored, and no counter logic is synthesised. Datapath behaviour is identical in both builds.

## Test plan
- Reset, then hold TX ingress valid with a 3-beat frame (tdata 0x1,0x2,0x3; last on beat 3) and m_axis_cmac_tready=1 → egress shows beats 0x1,0x2,0x3 on cycles 1,2,3 after acceptance; tx_pkt_cnt=1.
- Hold m_axis_cmac_tready=0, push DEPTH=4 beats → s_axis_adap_tready drops after the 4th push. Raise ready → 4 beats drain in order, then ready reasserts.
- Full FIFO with simultaneous s_tvalid=1 and m_tready=1 → exactly one pop, no push that cycle; occupancy 3. Push resumes next cycle.
- RX frame with tuser_err=1 on tlast, then a clean frame → both are forwarded intact; rx_pkt_cnt=2, rx_err_cnt=1; TX counters remain 0.
- Assert `rst` after beat 2 of a 4-beat frame held in the FIFO → tvalid=0 and tready=0 during reset; after release, no residual beats appear and counters=0.
- With STATS_EN, preload tx_pkt_cnt to all-ones (CNT_W=4, 15 frames) and send one more → stays 15. `stats_clr` coincident with a tlast handshake → reads 0.
